// File: rtl/seg7_vote_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg7_vote_decoder
// Brief    : Recovers the digit shown on a 7-segment vote-count display.
//            Synchronises and debounces the pattern, then decodes the digit
//            and raises a majority flag for three or more of five votes.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_vote_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          segs_in,
    output logic [3:0]          digit,
    output logic                digit_valid,
    output logic                blank,
    output logic                invalid,
    output logic                majority,
    output logic                update,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    // Count value at which a held candidate is considered stable.
    localparam logic [7:0] c_last = 8'(STABLE_CYCLES - 1);

    logic [6:0] r_s1;
    logic [6:0] r_s2;
    logic [6:0] r_cand;
    logic [7:0] r_cnt;
    logic [6:0] r_committed;

    logic [3:0] w_dec_digit;
    logic       w_dec_valid;
    logic       w_dec_blank;
    logic       w_dec_invalid;
    logic       w_dec_majority;
    logic       w_cand_new;
    logic       w_cand_short;
    logic       w_glitch_full;

    // ------------------------------------------------------------------------
    // Two-flop synchroniser for the asynchronous segment lines
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= segs_in;
            r_s2 <= r_s1;
        end
    end

    // ------------------------------------------------------------------------
    // Pattern decode of the candidate about to be committed
    // ------------------------------------------------------------------------
    always_comb begin
        w_dec_digit   = 4'd0;
        w_dec_valid   = 1'b1;
        w_dec_blank   = 1'b0;
        w_dec_invalid = 1'b0;
        case (r_cand)
            7'h3F: w_dec_digit = 4'd0;
            7'h06: w_dec_digit = 4'd1;
            7'h5B: w_dec_digit = 4'd2;
            7'h4F: w_dec_digit = 4'd3;
            7'h66: w_dec_digit = 4'd4;
            7'h6D: w_dec_digit = 4'd5;
            7'h7D: w_dec_digit = 4'd6;
            7'h07: w_dec_digit = 4'd7;
            7'h7F: w_dec_digit = 4'd8;
            7'h6F: w_dec_digit = 4'd9;
            7'h00: begin
                w_dec_valid = 1'b0;
                w_dec_blank = 1'b1;
            end
            default: begin
                w_dec_valid   = 1'b0;
                w_dec_invalid = 1'b1;
            end
        endcase
        w_dec_majority = w_dec_valid && (w_dec_digit >= 4'd3);
    end

    // A candidate differing from the committed pattern that is dropped before
    // it matured counts as one glitch.
    assign w_cand_new    = (r_cand != r_committed);
    assign w_cand_short  = (r_cnt < c_last);
    assign w_glitch_full = &glitch_cnt;

    // ------------------------------------------------------------------------
    // Stability filter, commit and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cand      <= '0;
            r_cnt       <= '0;
            r_committed <= '0;
            digit       <= 4'd0;
            digit_valid <= 1'b0;
            blank       <= 1'b1;
            invalid     <= 1'b0;
            majority    <= 1'b0;
            update      <= 1'b0;
            glitch_cnt  <= '0;
        end else begin
            update <= 1'b0;
            if (r_s2 != r_cand) begin
                r_cand <= r_s2;
                r_cnt  <= '0;
                if (w_cand_short && w_cand_new && !w_glitch_full) begin
                    glitch_cnt <= glitch_cnt + 1'b1;
                end
            end else if ((r_cnt == c_last) && w_cand_new) begin
                r_committed <= r_cand;
                digit       <= w_dec_digit;
                digit_valid <= w_dec_valid;
                blank       <= w_dec_blank;
                invalid     <= w_dec_invalid;
                majority    <= w_dec_majority;
                update      <= 1'b1;
            end else if (w_cand_short) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_vote_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_vote_decoder
// Brief    : Randomised scoreboard bench for seg7_vote_decoder with a
//            run-length reference model of the debounce/commit behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_vote_decoder;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] segs_in;

    logic [3:0] digit,  digit2;
    logic       valid,  valid2;
    logic       blank,  blank2;
    logic       inval,  inval2;
    logic       maj,    maj2;
    logic       upd,    upd2;
    logic [7:0] gcnt;
    logic [1:0] gcnt2;

    seg7_vote_decoder #(.STABLE_CYCLES(S), .GLITCH_W(8)) dut (
        .clk(clk), .rst(rst), .segs_in(segs_in),
        .digit(digit), .digit_valid(valid), .blank(blank), .invalid(inval),
        .majority(maj), .update(upd), .glitch_cnt(gcnt)
    );

    seg7_vote_decoder #(.STABLE_CYCLES(S), .GLITCH_W(2)) dut2 (
        .clk(clk), .rst(rst), .segs_in(segs_in),
        .digit(digit2), .digit_valid(valid2), .blank(blank2), .invalid(inval2),
        .majority(maj2), .update(upd2), .glitch_cnt(gcnt2)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         edge_no;
        logic [6:0] pat;
    } exp_t;
    exp_t sbq[$];

    logic [6:0] codes [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reference: {digit, valid, blank, invalid, majority}
    function automatic logic [7:0] ref_out(input logic [6:0] p);
        int d = -1;
        for (int k = 0; k < 10; k++) if (codes[k] == p) d = k;
        if (d >= 0)     return {4'(d), 1'b1, 1'b0, 1'b0, (d >= 3)};
        else if (p == 7'h00) return 8'h04;
        else            return 8'h02;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edge_n);
        end
    endtask

    // Run-length model: a maximal run of one pattern lasting at least S+1
    // cycles commits S+2 edges after it starts; a run shorter than S of a
    // non-committed pattern is a glitch.
    logic [6:0] m_comm;
    logic [6:0] run_pat;
    int         run_len;
    int         run_start;
    int         m_glitch;
    bit         fresh;
    bit         mon_en = 1'b0;
    int         upd_seen = 0;

    task automatic model_reset();
        sbq.delete();
        m_comm   = 7'h00;
        m_glitch = 0;
        fresh    = 1'b1;
    endtask

    task automatic model_step(input logic [6:0] p);
        exp_t e;
        if (fresh || p != run_pat) begin
            if (!fresh && run_len < S && run_pat != m_comm) m_glitch++;
            fresh     = 1'b0;
            run_pat   = p;
            run_len   = 1;
            run_start = edge_n + 1;
        end else begin
            run_len++;
        end
        if (run_len == S + 1 && run_pat != m_comm) begin
            e.edge_no = run_start + S + 2;
            e.pat     = p;
            sbq.push_back(e);
            m_comm = p;
        end
    endtask

    task automatic drive(input logic [6:0] p, input int len);
        for (int i = 0; i < len; i++) begin
            segs_in = p;
            model_step(p);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_out"},    32'({digit, valid, blank, inval, maj}), 32'h04);
        check({tag, "_out2"},   32'({digit2, valid2, blank2, inval2, maj2}), 32'h04);
        check({tag, "_update"}, 32'(upd), 32'd0);
        check({tag, "_glitch"}, 32'(gcnt), 32'd0);
        check({tag, "_glitch2"}, 32'(gcnt2), 32'd0);
    endtask

    task automatic check_steady(input string tag);
        logic [7:0] e = ref_out(m_comm);
        check({tag, "_out"},  32'({digit, valid, blank, inval, maj}), 32'(e));
        check({tag, "_out2"}, 32'({digit2, valid2, blank2, inval2, maj2}), 32'(e));
        check({tag, "_glitch"},  32'(gcnt),  32'((m_glitch > 255) ? 255 : m_glitch));
        check({tag, "_glitch2"}, 32'(gcnt2), 32'((m_glitch > 3) ? 3 : m_glitch));
    endtask

    // Monitor: pops one expectation for every update pulse seen.
    initial begin
        exp_t       e;
        logic [1:0] hot;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                hot = {1'b0, valid} + {1'b0, blank} + {1'b0, inval};
                check("one_flag", 32'(hot), 32'd1);
                if (upd !== 1'b0) begin
                    upd_seen++;
                    if (sbq.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_update: got update=%b expected none at edge %0d", upd, edge_n);
                    end else begin
                        e = sbq.pop_front();
                        check("update_edge", 32'(edge_n), 32'(e.edge_no));
                        check("update_out", 32'({digit, valid, blank, inval, maj}), 32'(ref_out(e.pat)));
                    end
                end
            end
        end
    end

    initial begin
        int         u0;
        int         sel;
        int         len;
        logic [6:0] p;

        rst     = 1'b1;
        segs_in = 7'h00;
        @(negedge clk);
        do_reset();
        mon_en = 1'b1;
        check_reset_vals("reset");

        drive(7'h00, 20);
        check("idle_pulses", 32'(upd_seen), 32'd0);
        check_steady("idle");

        u0 = upd_seen;
        drive(7'h4F, 12);
        check("step_pulses", 32'(upd_seen - u0), 32'd1);
        check("step_digit", 32'({digit, valid, maj}), 32'({4'd3, 1'b1, 1'b1}));
        check_steady("step");

        u0 = upd_seen;
        for (int k = 0; k < 10; k++) drive(codes[k], 10);
        drive(7'h00, 10);
        drive(7'h49, 10);
        check("sweep_pulses", 32'(upd_seen - u0), 32'd12);
        check("sweep_invalid", 32'({valid, blank, inval}), 32'b001);
        check_steady("sweep");

        drive(7'h06, 10);
        u0 = upd_seen;
        drive(7'h7F, 2);
        drive(7'h06, 10);
        check("bounce_pulses", 32'(upd_seen - u0), 32'd0);
        check("bounce_digit", 32'(digit), 32'd1);
        check_steady("bounce");

        drive(7'h6D, 5);
        do_reset();
        check_reset_vals("midreset");
        u0 = upd_seen;
        drive(7'h6D, 12);
        check("midreset_pulses", 32'(upd_seen - u0), 32'd1);
        check("midreset_digit", 32'(digit), 32'd5);
        check_steady("midreset");

        for (int k = 0; k < 5; k++) begin
            drive(codes[(k % 4) + 6], 2);
            drive(7'h6D, 6);
        end
        check("sat_glitch2", 32'(gcnt2), 32'd3);
        check_steady("sat");

        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 11);
            if (sel < 10)       p = codes[sel];
            else if (sel == 10) p = 7'h00;
            else                p = 7'($urandom_range(0, 127));
            len = $urandom_range(1, S + 4);
            drive(p, len);
        end
        drive(codes[$urandom_range(0, 9)], S + 8);
        check_steady("random");
        check("queue_drained", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_vote_decoder.md
Name: seg7_vote_decoder

Overview:
- Receive end of the vote-display path: takes a 7-segment pattern, as driven onto the display by the vote-count encoder, and recovers the digit it shows.
- Synchronises and glitch-filters the pattern, decodes it to a 4-bit digit with blank/invalid flags, and derives a majority flag (count >= 3 of 5 voters).
- Used for board-level loopback checking and for feeding the displayed count back into downstream control logic.

Parameters:
- STABLE_CYCLES, 4, consecutive synchronised cycles a pattern must hold before it is accepted; legal range 1..255.
- GLITCH_W, 8, width of the saturating glitch counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- segs_in  in  7  segment pattern {g,f,e,d,c,b,a}, active-high; asynchronous to clk.
- digit  out  4  last accepted decoded digit, 0..9.
- digit_valid  out  1  accepted pattern is a legal digit 0..9.
- blank  out  1  accepted pattern is 7'h00.
- invalid  out  1  accepted pattern is neither a digit nor blank.
- majority  out  1  digit_valid && digit >= 3.
- update  out  1  one-cycle pulse on each accepted pattern change.
- glitch_cnt  out  GLITCH_W  count of candidate patterns abandoned before becoming stable; saturates.

Behaviour:
- Reset (synchronous, rst high at an edge), all cleared:
  - sync stages s1 and s2 = 0; cand = 0; cnt = 0; committed = 7'h00.
  - digit = 0, digit_valid = 0, blank = 1, invalid = 0, majority = 0, update = 0, glitch_cnt = 0.
  - A reset mid-filter discards the candidate; no update is issued for it.
- Synchroniser: s1 <= segs_in; s2 <= s1 (2 flops, no reset bypass).
- Filter, evaluated every edge with this priority:
  - If s2 != cand: cand <= s2; cnt <= 0. If additionally cnt < STABLE_CYCLES-1 and cand != committed, glitch_cnt <= glitch_cnt+1, saturating at all-ones.
  - Else if cnt == STABLE_CYCLES-1 and cand != committed: commit. committed <= cand, outputs reload from the decode of cand, update <= 1.
  - Else if cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - update is 0 on every edge that does not commit.
- Latency: a step on segs_in held steady produces update and new outputs STABLE_CYCLES+3 edges later (7 at default; 4 when STABLE_CYCLES = 1).
- No re-commit: a pattern equal to committed never pulses update. A pattern held indefinitely gives exactly one update.
- Decode (committed pattern -> digit):
  - 7'h3F -> 0, 7'h06 -> 1, 7'h5B -> 2, 7'h4F -> 3, 7'h66 -> 4, 7'h6D -> 5, 7'h7D -> 6, 7'h07 -> 7, 7'h7F -> 8, 7'h6F -> 9.
  - 7'h00 -> blank = 1, digit = 0, digit_valid = 0.
  - Any other pattern -> invalid = 1, digit = 0, digit_valid = 0.
  - Exactly one of digit_valid, blank, invalid is high at all times.
- majority: registered together with digit, so it has the same timing.
- Flicker: a pattern shorter than STABLE_CYCLES synchronised cycles never reaches the outputs.
- A→B→A bounce: if the pattern returns to committed before B is accepted, there is no update; the abandoned B candidate increments glitch_cnt once.

Test Plan:
- Reset with segs_in = 7'h00, held 20 cycles -> blank = 1, update never pulses, glitch_cnt = 0.
- Step segs_in 7'h00 -> 7'h4F, held -> update pulses for exactly 1 cycle at edge 7 after the step; digit = 3, digit_valid = 1, majority = 1; no further pulses.
- Drive all 10 digit codes, then 7'h00, then 7'h49, each held 10 cycles -> digits 0..9 in order; majority high only for 3..9; then blank = 1; then invalid = 1. 12 update pulses total.
- With 7'h06 committed, pulse 7'h7F for 2 cycles, then return to 7'h06 -> no update, digit stays 1, glitch_cnt = 1.
- Assert rst for 1 cycle while a new pattern 7'h6D is mid-filter (cnt = 2) -> all outputs at reset values next cycle. With 7'h6D still applied, update follows 7 edges after rst deasserts; digit = 5.
- Set GLITCH_W = 2 and apply 5 abandoned flickers -> glitch_cnt saturates at 3.
